merge_arb: RTL
==============

# merge_arb

Clocked two-input arbitrated merge for 4-phase bundled-data channels: the converging counterpart of the copy (fork) stage. Packets arriving on L0 or L1 are forwarded, one at a time and in full, onto the single output channel R. Round-robin arbitration guarantees fairness when both inputs request. It sits wherever two PE result streams converge onto one downstream channel.

## Interface
- WIDTH, 4, packet data width in bits.

- clk  in  1  rising-edge clock; all handshake inputs are synchronous to it.
- rst_n  in  1  asynchronous, active-low reset.
- L0_req  in  1  input channel 0 request (4-phase).
- L0_data  in  WIDTH  input channel 0 data; stable while L0_req=1.
- L0_ack  out  1  input channel 0 acknowledge.
- L1_req  in  1  input channel 1 request.
- L1_data  in  WIDTH  input channel 1 data; stable while L1_req=1.
- L1_ack  out  1  input channel 1 acknowledge.
- R_req  out  1  output request.
- R_data  out  WIDTH  output data; stable while R_req=1.
- R_src  out  1  index of the input that supplied R_data; valid while R_req=1.
- R_ack  in  1  output acknowledge.

## Operation
- FSM states: IDLE, SEND, RELEASE, ACK_IN, ACK_DONE.
- IDLE: sample L0_req and L1_req.
  - If exactly one is high, grant it.
  - If both are high, grant the input named by the priority pointer `prio`.
  - On grant: latch the winner's data into R_data, set R_src=winner, `gnt`=winner, `prio`=~winner, R_req<=1, go to SEND.
- SEND: hold R_req=1. When R_ack=1 is sampled: R_req<=0, go to RELEASE.
- RELEASE: when R_ack=0 is sampled: L[gnt]_ack<=1, go to ACK_IN.
- ACK_IN: when L[gnt]_req=0 is sampled: L[gnt]_ack<=0, go to ACK_DONE.
- ACK_DONE: return to IDLE, so the next grant is evaluated one cycle later. This cycle guarantees that a freshly released request is never re-sampled as stale.
- Only L[gnt]_ack is ever driven high. The non-granted input's request stays pending, unacknowledged and unlatched, until it is granted.
- The `prio` pointer updates on every grant, including uncontested ones, so a lone requester always hands priority to the other input.
- R_data and R_src are registered. They hold their last value outside SEND; a bench checks them only while R_req=1.

## Timing
- Reset (rst_n=0, asynchronous): state=IDLE, prio=0, gnt=0, R_req=0, R_data=0, R_src=0, L0_ack=0, L1_ack=0.
  - Outputs clear immediately on assertion, without waiting for a clock edge.
  - Reset asserted mid-transfer abandons the packet. Channel partners must be reset together with this block.
- Forward latency: L_req sampled high at edge n -> R_req=1 after edge n.
- R_ack sampled high at edge m -> R_req=0 after edge m.
- R_ack sampled low at edge k -> L[gnt]_ack=1 after edge k.
- L[gnt]_req sampled low at edge j -> L_ack=0 after edge j. The earliest next grant is at edge j+2.
- With an environment that responds one cycle after each edge, one packet takes 8 cycles from request to being ready for the next.
- There is no timeout. A stalled R_ack or L_req holds the FSM in its current state indefinitely, and all outputs stay stable.
- Simultaneous requests in IDLE are resolved by `prio` alone. A request arriving during a transfer waits; it is neither lost nor duplicated.
- Requests must obey 4-phase rules. Behaviour under protocol violations, such as a req dropping before its ack, is unspecified and not checked.

## Test plan
- Reset: drive rst_n=0 with random inputs -> every output reads 0 at once, with no clock edge needed. After release, the first contested grant goes to L0.
- Single L0 packet: L0_data=4'b1010, L0_req=1 -> R_req=1, R_data=1010, R_src=0. After the R_ack up/down handshake, L0_ack goes high, then low after L0_req drops. L1_ack stays 0 throughout.
- Contention: assert L0_req with 1010 and L1_req with 0101 on the same cycle after reset -> R delivers 1010 (src 0) first, then 0101 (src 1). L1_ack stays 0 until the second grant.
- Fairness: both inputs re-request immediately after every ack, for 6 packets -> R_src sequence is 0,1,0,1,0,1.
- Backpressure: hold R_ack=0 for 10 cycles after R_req rises -> R_req, R_data and R_src stay constant, and both L_acks stay 0.
- Reset mid-SEND: pulse rst_n low while R_req=1 -> R_req=0 immediately. After release, a new L1-only request (0011) is delivered correctly, and the pointer has restarted at L0.

Source files
------------

// File: rtl/merge_arb.sv
// Two-input round-robin merge of 4-phase bundled-data channels onto one output channel.
// One cycle from sampled request to R_req; a stalled R_ack or L_req holds all outputs stable.
module merge_arb #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             L0_req,
  input  logic [WIDTH-1:0] L0_data,
  output logic             L0_ack,
  input  logic             L1_req,
  input  logic [WIDTH-1:0] L1_data,
  output logic             L1_ack,
  output logic             R_req,
  output logic [WIDTH-1:0] R_data,
  output logic             R_src,
  input  logic             R_ack
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SEND     = 3'd1,
    RELEASE  = 3'd2,
    ACK_IN   = 3'd3,
    ACK_DONE = 3'd4
  } state_t;

  state_t state;
  state_t state_nxt;

  logic prio;
  logic gnt;
  logic gnt_req;
  logic grant_fire;
  logic winner;

  logic r_req_nxt;
  logic l0_ack_nxt;
  logic l1_ack_nxt;

  assign gnt_req    = gnt ? L1_req : L0_req;
  assign grant_fire = (state == IDLE) && (L0_req || L1_req);
  // A lone requester wins outright; only a tie consults the pointer.
  assign winner     = (L0_req && L1_req) ? prio : L1_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (L0_req || L1_req) state_nxt = SEND;
      SEND:     if (R_ack)            state_nxt = RELEASE;
      RELEASE:  if (!R_ack)           state_nxt = ACK_IN;
      ACK_IN:   if (!gnt_req)         state_nxt = ACK_DONE;
      ACK_DONE:                       state_nxt = IDLE;
      default:                        state_nxt = IDLE;
    endcase
  end

  // Handshake outputs are decoded from the next state and then registered,
  // so each one toggles cleanly from a single flop.
  always_comb begin
    r_req_nxt  = 1'b0;
    l0_ack_nxt = 1'b0;
    l1_ack_nxt = 1'b0;
    case (state_nxt)
      SEND:    r_req_nxt  = 1'b1;
      ACK_IN: begin
        l0_ack_nxt = ~gnt;
        l1_ack_nxt = gnt;
      end
      default: begin
        r_req_nxt  = 1'b0;
        l0_ack_nxt = 1'b0;
        l1_ack_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      R_req  <= 1'b0;
      L0_ack <= 1'b0;
      L1_ack <= 1'b0;
    end else begin
      R_req  <= r_req_nxt;
      L0_ack <= l0_ack_nxt;
      L1_ack <= l1_ack_nxt;
    end
  end

  // The pointer moves on every grant so a lone requester still yields the next tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      R_data <= '0;
      R_src  <= 1'b0;
      gnt    <= 1'b0;
      prio   <= 1'b0;
    end else if (grant_fire) begin
      R_data <= winner ? L1_data : L0_data;
      R_src  <= winner;
      gnt    <= winner;
      prio   <= ~winner;
    end
  end

  a_one_ack: assert property (@(posedge clk) disable iff (!rst_n)
    !(L0_ack && L1_ack));

  a_r_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (R_req && !R_ack) |=> (R_req && $stable(R_data) && $stable(R_src)));

endmodule
